// File: rtl/rom_pkg.sv
// Shared definitions for the parametrised instruction ROM: NOP word, load FSM states, fetch address check.
package rom_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE,
        ST_LOADING
    } load_state_e;

    // Fetch is legal only when word aligned and inside the populated array.
    function automatic logic addr_ok(input logic [63:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && (addr < (64'(depth) << 2));
    endfunction

endpackage

// File: rtl/rom_pipe_delay.sv
// Delays a valid/err/data read result by DEPTH register stages; no backpressure, one result per cycle.
module rom_pipe_delay #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld_i,
    input  logic             in_err_i,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    output logic             out_err_o,
    output logic [WIDTH-1:0] out_dat_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] err_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld_i;
            err_q[0] <= in_err_i;
            dat_q[0] <= in_dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld_o = vld_q[DEPTH-1];
    assign out_err_o = err_q[DEPTH-1];
    assign out_dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/rom_instr_param.sv
// Instruction ROM with run-time load burst and pipelined byte-addressed fetch; responses arrive LATENCY
// cycles after accept, fetch_ready drops while loading or when load_start is raised, no response backpressure.
module rom_instr_param
    import rom_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int A_WIDTH   = $clog2(MEM_DEPTH),
    parameter int ADDR_W    = 32,
    parameter int LATENCY   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [D_WIDTH-1:0] load_data,
    input  logic               load_last,
    output logic               load_busy,
    output logic               load_done,
    output logic [A_WIDTH:0]   load_count,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic               fetch_valid,
    output logic [D_WIDTH-1:0] fetch_data,
    output logic               fetch_err
);

    localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(MEM_DEPTH - 1);
    localparam logic [D_WIDTH-1:0] NOP_D    = D_WIDTH'(NOP_INSTR);

    load_state_e        state_q, state_d;
    logic [A_WIDTH-1:0] ptr_q, ptr_d;
    logic [A_WIDTH:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               wr_en;

    logic [D_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOADING;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOADING: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + A_WIDTH'(1);
                    cnt_d = cnt_q + (A_WIDTH + 1)'(1);
                    // The last array slot closes the burst even without load_last: no wrap-around.
                    if (load_last || (ptr_q == LAST_IDX)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= load_data;
        end
    end

    assign load_busy  = (state_q == ST_LOADING);
    assign load_done  = done_q;
    assign load_count = cnt_q;

    logic               accept;
    logic               req_ok;
    logic [A_WIDTH-1:0] word_idx;
    logic [D_WIDTH-1:0] rd_dat;

    assign fetch_ready = (state_q == ST_IDLE) && !load_start;
    assign accept      = fetch_req && fetch_ready;
    assign req_ok      = addr_ok(64'(fetch_addr), MEM_DEPTH);
    assign word_idx    = fetch_addr[A_WIDTH+1:2];
    assign rd_dat      = req_ok ? mem[word_idx] : NOP_D;

    // Stage 1 captures the array read at the accept edge, so a later load cannot disturb it.
    logic               s1_vld_q;
    logic               s1_err_q;
    logic [D_WIDTH-1:0] s1_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_err_q <= !req_ok;
                s1_dat_q <= rd_dat;
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            rom_pipe_delay #(
                .WIDTH (D_WIDTH),
                .DEPTH (LATENCY - 1)
            ) u_pipe (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_vld_i  (s1_vld_q),
                .in_err_i  (s1_err_q),
                .in_dat_i  (s1_dat_q),
                .out_vld_o (fetch_valid),
                .out_err_o (fetch_err),
                .out_dat_o (fetch_data)
            );
        end else begin : g_direct
            assign fetch_valid = s1_vld_q;
            assign fetch_err   = s1_err_q;
            assign fetch_data  = s1_dat_q;
        end
    endgenerate

endmodule
